// File: rtl/riscv_trace_pkg.sv
// Shared definitions for the RISC-V trace capture unit.
//
// Contents:
//   TRACE_WORDS  number of 32-bit stream words per trace record
//   REC_W        packed record width, {pc, wb, alu}
//   *_LSB        bit offsets of each field inside a packed record
//   ser_state_t  serializer FSM states
package riscv_trace_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned TRACE_WORDS = 3;
    localparam int unsigned REC_W       = WORD_W * TRACE_WORDS;

    // Record layout: PC [95:64], WB [63:32], ALU [31:0]
    localparam int unsigned PC_LSB  = 64;
    localparam int unsigned WB_LSB  = 32;
    localparam int unsigned ALU_LSB = 0;

    // Serializer states; S_PC/S_WB/S_ALU name the word currently on out_data
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PC   = 2'd1,
        S_WB   = 2'd2,
        S_ALU  = 2'd3
    } ser_state_t;

endpackage

// File: rtl/riscv_trace_capture_fifo.sv
// trace_fifo: synchronous single-clock FIFO holding packed trace records.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   push         write push_data (ignored when full unless pop on the same edge)
//   push_data    record to store
//   pop          remove the head record (ignored when empty)
//   pop_data     head record, valid whenever empty is low
//   full, empty  derived from count
//   count        records currently stored, 0..DEPTH
//
// A push while full is accepted when a pop happens on the same edge: the head is
// read combinationally before the edge, so the write may land in the freed slot.
module trace_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_trace_capture.sv
// riscv_trace_capture: records one {pc, wb, alu} entry per distinct PC seen on the
// core's observation buses, buffers entries in a FIFO and emits each as three
// 32-bit words on a valid/ready stream (PC, WB, ALU; out_last on ALU).
//
// Ports:
//   clk, rst     core clock, synchronous active-high reset
//   cap_en       capture enable; deassertion stops new captures, buffered records drain
//   pc_in        core PC
//   wb_in        core WB1_OUT
//   alu_in       core EX_MEM_ALUOUT
//   out_data     current stream word
//   out_valid    out_data is valid
//   out_ready    consumer accepts the word
//   out_last     marks the ALU (third) word of a record
//   fifo_count   records in the FIFO, not counting the one in the serializer
//   drop_cnt     records lost to overflow, saturating
module riscv_trace_capture
    import riscv_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              wb_in,
    input  logic [31:0]              alu_in,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         drop_cnt
);

    // Capture-side state
    logic [31:0]      last_pc;
    logic             pc_valid;
    logic             capture;
    logic             accept;

    // FIFO interface
    logic [REC_W-1:0] push_rec;
    logic [REC_W-1:0] head_rec;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    // Serializer state; hold keeps the WB and ALU words of the record in flight,
    // the PC word goes straight from the FIFO head into out_data.
    ser_state_t       state;
    logic [63:0]      hold;
    logic             load;

    // ------------------------------------------------------------------
    // Capture
    // ------------------------------------------------------------------
    assign capture  = cap_en && (!pc_valid || (pc_in != last_pc));
    assign push_rec = {pc_in, wb_in, alu_in};

    // Load event: idle, or the ALU word handshakes this edge.
    assign load = (state == S_IDLE) || ((state == S_ALU) && out_ready);
    assign pop  = load && !fifo_empty;

    // A full FIFO still takes the record when the serializer pops on this edge.
    assign accept = capture && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc  <= '0;
            pc_valid <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // last_pc advances even when the record is dropped, so a stalled
            // PC does not generate repeated drop counts.
            if (capture) begin
                last_pc  <= pc_in;
                pc_valid <= 1'b1;
            end
            if (capture && !accept && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Record buffer
    // ------------------------------------------------------------------
    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (push_rec),
        .pop       (pop),
        .pop_data  (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Serializer: outputs are registered together with the state so that
    // out_valid == (state != S_IDLE) and out_last == (state == S_ALU) hold
    // by construction, and nothing changes while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hold      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_ALU: begin
                    if (load) begin
                        if (!fifo_empty) begin
                            hold      <= head_rec[63:0];
                            out_data  <= head_rec[PC_LSB +: 32];
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            state     <= S_PC;
                        end else begin
                            out_data  <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_PC: begin
                    if (out_ready) begin
                        out_data <= hold[WB_LSB +: 32];
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (out_ready) begin
                        out_data <= hold[ALU_LSB +: 32];
                        out_last <= 1'b1;
                        state    <= S_ALU;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_trace_capture.sv
module tb_riscv_trace_capture;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cap_en;
    logic [31:0]            pc_in;
    logic [31:0]            wb_in;
    logic [31:0]            alu_in;
    logic [31:0]            out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0]       drop_cnt;

    // Scoreboard entries are {last, data}
    logic [32:0] sb[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          words_seen = 0;

    riscv_trace_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .pc_in      (pc_in),
        .wb_in      (wb_in),
        .alu_in     (alu_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Stream monitor: compares every handshaked word to the scoreboard and
    // checks that a stalled word does not change.
    initial begin : monitor
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [32:0] exp_w;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_checks++;
                    if (out_data !== prev_data || out_last !== prev_last
                        || out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_stable: got data=%h last=%b valid=%b, required data=%h last=%b valid=1",
                                 out_data, out_last, out_valid, prev_data, prev_last);
                    end
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    words_seen++;
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL word_unexpected: got data=%h last=%b, required no word",
                                 out_data, out_last);
                    end else begin
                        exp_w = sb.pop_front();
                        if ({out_last, out_data} !== exp_w) begin
                            n_fail++;
                            $display("FAIL word: got data=%h last=%b, required data=%h last=%b",
                                     out_data, out_last, exp_w[31:0], exp_w[32]);
                        end
                    end
                end
                prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cap_en    = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic push_rec(input logic [31:0] p, input logic [31:0] w, input logic [31:0] a);
        sb.push_back({1'b0, p});
        sb.push_back({1'b0, w});
        sb.push_back({1'b1, a});
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int cnt = 0;
        while ((sb.size() != 0 || out_valid !== 1'b0) && cnt < budget) begin
            tick();
            cnt++;
        end
        ok = (sb.size() == 0) && (out_valid === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cap_en    = 1'b1;
            pc_in     = $urandom;
            wb_in     = $urandom;
            alu_in    = $urandom;
            out_ready = 1'($urandom);
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h, required 0 0 00000000",
                     out_valid, out_last, out_data);
        end
        n_checks++;
        if (fifo_count !== 0 || drop_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_counts: got fifo_count=%0d drop_cnt=%0d, required 0 0",
                     fifo_count, drop_cnt);
        end
        rst       = 1'b0;
        cap_en    = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        // Captures presented during reset must not have been stored
        n_checks++;
        if (fifo_count !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_capture_ignored: got fifo_count=%0d valid=%b, required 0 0",
                     fifo_count, out_valid);
        end
    endtask

    task automatic test_single();
        int w0;
        bit ok;
        do_reset();
        w0        = words_seen;
        out_ready = 1'b1;
        cap_en    = 1'b1;
        pc_in     = 32'h0;
        wb_in     = 32'h3;
        alu_in    = 32'h3;
        push_rec(32'h0, 32'h3, 32'h3);
        @(posedge clk);  // sample edge E
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency_early: got valid=%b one cycle after sample, required 0",
                     out_valid);
        end
        @(posedge clk);  // E+1: pop
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%b data=%h last=%b, required 1 00000000 0",
                     out_valid, out_data, out_last);
        end
        repeat (3) tick();
        cap_en = 1'b0;
        wait_idle(50, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_drain: got %0d words pending, required 0", sb.size());
        end
        n_checks++;
        if (words_seen - w0 != 3) begin
            n_fail++;
            $display("FAIL single_word_count: got %0d, required 3", words_seen - w0);
        end
    endtask

    task automatic test_stream();
        int w0;
        int first_v = -1;
        int last_v  = -1;
        int n_v     = 0;
        bit ok;
        do_reset();
        w0        = words_seen;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i < 3) begin
                cap_en = 1'b1;
                pc_in  = 32'(4 * i);
                wb_in  = 32'h1000 + 32'(i);
                alu_in = 32'h2000 + 32'(i);
                push_rec(pc_in, wb_in, alu_in);
            end else begin
                cap_en = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                n_v++;
            end
        end
        n_checks++;
        if (n_v != 9 || last_v - first_v + 1 != 9) begin
            n_fail++;
            $display("FAIL stream_contiguous: got %0d valid cycles spanning %0d, required 9 spanning 9",
                     n_v, last_v - first_v + 1);
        end
        n_checks++;
        if (first_v != 1) begin
            n_fail++;
            $display("FAIL stream_first_word: got cycle %0d, required 1", first_v);
        end
        tick();
        wait_idle(50, ok);
        n_checks++;
        if (!ok || words_seen - w0 != 9) begin
            n_fail++;
            $display("FAIL stream_words: got %0d words (pending %0d), required 9 (pending 0)",
                     words_seen - w0, sb.size());
        end
    endtask

    task automatic test_overflow();
        int w0;
        bit ok;
        do_reset();
        w0        = words_seen;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cap_en = 1'b1;
            pc_in  = 32'h100 + 32'(4 * i);
            wb_in  = 32'h5000 + 32'(i);
            alu_in = 32'h6000 + 32'(i);
            // Record 0 sits in the serializer, 1..8 fill the FIFO, 9..11 drop
            if (i < 9) push_rec(pc_in, wb_in, alu_in);
            tick();
        end
        cap_en = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 8) begin
            n_fail++;
            $display("FAIL overflow_fifo_count: got %0d, required 8", fifo_count);
        end
        n_checks++;
        if (drop_cnt !== 3) begin
            n_fail++;
            $display("FAIL overflow_drop_cnt: got %0d, required 3", drop_cnt);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h100 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_head: got valid=%b data=%h last=%b, required 1 00000100 0",
                     out_valid, out_data, out_last);
        end
        tick();
        out_ready = 1'b1;
        wait_idle(200, ok);
        n_checks++;
        if (!ok || words_seen - w0 != 27) begin
            n_fail++;
            $display("FAIL overflow_drain: got %0d words (pending %0d), required 27 (pending 0)",
                     words_seen - w0, sb.size());
        end
        n_checks++;
        if (fifo_count !== 0 || drop_cnt !== 3) begin
            n_fail++;
            $display("FAIL overflow_after: got fifo_count=%0d drop_cnt=%0d, required 0 3",
                     fifo_count, drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        int w0;
        int cnt = 0;
        do_reset();
        w0 = words_seen;
        for (int i = 0; i < 6; i++) begin
            cap_en    = 1'b1;
            pc_in     = 32'h200 + 32'(4 * i);
            wb_in     = $urandom;
            alu_in    = $urandom;
            out_ready = 1'($urandom);
            push_rec(pc_in, wb_in, alu_in);
            tick();
        end
        cap_en = 1'b0;
        while ((sb.size() != 0 || out_valid !== 1'b0) && cnt < 300) begin
            out_ready = 1'($urandom);
            tick();
            cnt++;
        end
        n_checks++;
        if (sb.size() != 0 || words_seen - w0 != 18) begin
            n_fail++;
            $display("FAIL backpressure_words: got %0d words (pending %0d), required 18 (pending 0)",
                     words_seen - w0, sb.size());
        end
        n_checks++;
        if (drop_cnt !== 0) begin
            n_fail++;
            $display("FAIL backpressure_drop: got %0d, required 0", drop_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w0;
        bit ok;
        do_reset();
        out_ready = 1'b0;
        cap_en    = 1'b1;
        pc_in     = 32'h40;
        wb_in     = 32'h41;
        alu_in    = 32'h42;
        push_rec(pc_in, wb_in, alu_in);
        tick();
        cap_en = 1'b0;
        tick();
        out_ready = 1'b1;  // accept the PC word only
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h41 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_wb_word: got valid=%b data=%h last=%b, required 1 00000041 0",
                     out_valid, out_data, out_last);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || fifo_count !== 0) begin
            n_fail++;
            $display("FAIL midrst_cleared: got valid=%b last=%b fifo_count=%0d, required 0 0 0",
                     out_valid, out_last, fifo_count);
        end
        tick();
        w0        = words_seen;
        out_ready = 1'b1;
        cap_en    = 1'b1;  // same PC as before reset
        push_rec(32'h40, 32'h41, 32'h42);
        tick();
        cap_en = 1'b0;
        wait_idle(50, ok);
        n_checks++;
        if (!ok || words_seen - w0 != 3) begin
            n_fail++;
            $display("FAIL midrst_recapture: got %0d words (pending %0d), required 3 (pending 0)",
                     words_seen - w0, sb.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        cap_en    = 1'b0;
        out_ready = 1'b0;
        pc_in     = '0;
        wb_in     = '0;
        alu_in    = '0;
        test_reset();
        test_single();
        test_stream();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
